axi_dual_master_arbiter: RTL
============================

# axi_dual_master_arbiter

Shares one AXI4 slave port (the DDR-SDRAM controller's) between two AXI4 masters, for example two `axi_self_test_master` instances or a test master plus user logic. The write path (AW/W/B) and read path (AR/R) are arbitrated independently with round-robin priority. Each path is locked to its granted master for a whole burst, so at most one write burst and one read burst are outstanding. It sits directly in front of the controller's AXI slave port.

## Interface
- A_WIDTH, 26, address width of all AW/AR channels
- D_WIDTH, 16, data width of all W/R channels
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- m_awvalid in [1:0], m_awready out [1:0], m_awaddr in [2*A_WIDTH-1:0], m_awlen in [15:0]  master AW; master i in slice i
- m_wvalid in [1:0], m_wready out [1:0], m_wlast in [1:0], m_wdata in [2*D_WIDTH-1:0]  master W
- m_bvalid out [1:0], m_bready in [1:0]  master B
- m_arvalid in [1:0], m_arready out [1:0], m_araddr in [2*A_WIDTH-1:0], m_arlen in [15:0]  master AR
- m_rvalid out [1:0], m_rready in [1:0], m_rlast out [1:0], m_rdata out [2*D_WIDTH-1:0]  master R
- s_awvalid out 1, s_awready in 1, s_awaddr out A_WIDTH, s_awlen out 8  slave AW
- s_wvalid out 1, s_wready in 1, s_wlast out 1, s_wdata out D_WIDTH  slave W
- s_bvalid in 1, s_bready out 1  slave B
- s_arvalid out 1, s_arready in 1, s_araddr out A_WIDTH, s_arlen out 8  slave AR
- s_rvalid in 1, s_rready out 1, s_rlast in 1, s_rdata in D_WIDTH  slave R
- wgrant out [1:0], rgrant out [1:0]  one-hot current owner of each path; 0 in idle
- wlast_err out 1  one-cycle pulse on a write-beat length mismatch
- wlast_err_cnt out 16  saturating count of wlast_err pulses

## Operation
- Write FSM states: WIDLE, WAW, WDAT, WRSP.
  - WIDLE: if any m_awvalid, register the grant and go to WAW.
  - WAW: leave on s_awvalid&&s_awready; go to WDAT and clear the beat counter.
  - WDAT: leave on s_wvalid&&s_wready&&s_wlast; go to WRSP.
  - WRSP: leave on s_bvalid&&s_bready; go to WIDLE and record the last-granted write master.
- Read FSM states: RIDLE, RAR, RDAT.
  - RIDLE: if any m_arvalid, register the grant and go to RAR.
  - RAR: leave on the AR handshake; go to RDAT.
  - RDAT: leave on s_rvalid&&s_rready&&s_rlast; go to RIDLE and record the last-granted read master.
- Round-robin: if both masters request, grant the one not granted last. A lone requester always wins. The last-granted register resets to master 1, so master 0 wins the first tie.
- Forwarding is combinational from the granted slice g, and only in the matching state:
  - AW and AR: s_*valid, addr, len come from slice g. s_*ready goes to m_*ready[g].
  - W: wvalid, wdata, wlast come from slice g. s_wready goes to m_wready[g].
  - B: s_bvalid goes to m_bvalid[g]. s_bready = m_bready[g].
  - R: s_rvalid and s_rlast go to m_rvalid[g] and m_rlast[g]. s_rready = m_rready[g]. s_rdata is broadcast to both m_rdata slices.
- In every other state, or for the non-granted master:
  - All valid and ready outputs are 0.
  - s_awaddr, s_awlen, s_araddr, s_arlen and s_wdata show slice 0.
- Beat check: an 8-bit counter increments on each W handshake in WDAT.
  - wlast_err fires the cycle after a W handshake where (m_wlast[g]) != (count == latched awlen).
  - On a mismatch, the beat is still forwarded unchanged.
  - wlast_err_cnt increments on each pulse and saturates at 16'hFFFF.

## Timing
- Reset (areset high, asynchronous) puts both FSMs in IDLE and sets:
  - wgrant = rgrant = 0
  - all valid and ready outputs to 0
  - wlast_err = 0 and wlast_err_cnt = 0
- Arbitration latency: a request seen in IDLE at edge n drives s_awvalid/s_arvalid high from cycle n+1. There is no combinational path from m_*valid to s_*valid in IDLE.
- Returning to IDLE costs one cycle. A new grant is possible the cycle after the burst ends.
- The write and read paths run concurrently and never block each other.
- A master that drops its request before its grant appears is still granted. The grant holds until that master completes the handshake, as AXI forbids dropping valid.
- Reset mid-burst abandons the burst with no recovery. The slave is reset by the same areset.

## Test plan
- Single master 0 writes a burst (awaddr 0x40, awlen 7, 8 beats) then reads it back (araddr 0x40, arlen 7) -> wgrant = 01 for the write, rgrant = 01 for the read, 8 rdata beats reach m_rdata slice 0, master 1 sees no valid, wlast_err_cnt = 0.
- Both masters raise awvalid in the same cycle after reset -> master 0 is granted first, master 1 next; order alternates 0,1,0,1 over 4 bursts each.
- A write by master 1 runs concurrently with a read by master 0 -> both complete with no stall from the other path; s_bready tracks m_bready[1].
- Slave holds s_awready, s_wready and s_rvalid low for 5 cycles mid-burst -> grant held, no beat lost or duplicated, data order preserved.
- Master asserts wlast on beat 3 of awlen 7 -> exactly one wlast_err pulse the cycle after beat 3, wlast_err_cnt = 1; FSM goes to WRSP and completes.
- areset is pulsed during WDAT -> all outputs return to reset values within the reset cycle; a fresh write afterwards completes normally.

Source files
------------

// File: rtl/axi_dual_master_arbiter.sv
// axi_dual_master_arbiter
// Shares one AXI4 slave port (the DDR controller) between two AXI4 masters.
// The write path (AW/W/B) and the read path (AR/R) each have an independent
// round-robin arbiter. A path stays locked to its granted master for a whole
// burst, so at most one write burst and one read burst are in flight.
//
// Ports
//   aclk, areset            clock, asynchronous active-high reset
//   m_aw*/m_w*/m_b*         master write channels, master i in slice i
//   m_ar*/m_r*              master read channels, master i in slice i
//   s_aw*/s_w*/s_b*         slave write channels
//   s_ar*/s_r*              slave read channels
//   wgrant, rgrant          one-hot owner of each path, 0 when idle
//   wlast_err               one-cycle pulse on a write beat-count mismatch
//   wlast_err_cnt           saturating count of wlast_err pulses
//
// state | meaning
// WIDLE | no write owner; arbitrate m_awvalid
// WAW   | forward AW of the granted master
// WDAT  | forward W beats, check beat count against awlen
// WRSP  | forward B response back to the granted master
// RIDLE | no read owner; arbitrate m_arvalid
// RAR   | forward AR of the granted master
// RDAT  | forward R beats until rlast
module axi_dual_master_arbiter #(
   parameter int A_WIDTH = 26,
   parameter int D_WIDTH = 16
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic [1:0]           m_awvalid,
   output logic [1:0]           m_awready,
   input  logic [2*A_WIDTH-1:0] m_awaddr,
   input  logic [15:0]          m_awlen,
   input  logic [1:0]           m_wvalid,
   output logic [1:0]           m_wready,
   input  logic [1:0]           m_wlast,
   input  logic [2*D_WIDTH-1:0] m_wdata,
   output logic [1:0]           m_bvalid,
   input  logic [1:0]           m_bready,
   input  logic [1:0]           m_arvalid,
   output logic [1:0]           m_arready,
   input  logic [2*A_WIDTH-1:0] m_araddr,
   input  logic [15:0]          m_arlen,
   output logic [1:0]           m_rvalid,
   input  logic [1:0]           m_rready,
   output logic [1:0]           m_rlast,
   output logic [2*D_WIDTH-1:0] m_rdata,
   output logic                 s_awvalid,
   input  logic                 s_awready,
   output logic [A_WIDTH-1:0]   s_awaddr,
   output logic [7:0]           s_awlen,
   output logic                 s_wvalid,
   input  logic                 s_wready,
   output logic                 s_wlast,
   output logic [D_WIDTH-1:0]   s_wdata,
   input  logic                 s_bvalid,
   output logic                 s_bready,
   output logic                 s_arvalid,
   input  logic                 s_arready,
   output logic [A_WIDTH-1:0]   s_araddr,
   output logic [7:0]           s_arlen,
   input  logic                 s_rvalid,
   output logic                 s_rready,
   input  logic                 s_rlast,
   input  logic [D_WIDTH-1:0]   s_rdata,
   output logic [1:0]           wgrant,
   output logic [1:0]           rgrant,
   output logic                 wlast_err,
   output logic [15:0]          wlast_err_cnt
);

   typedef enum logic [1:0] {WIDLE, WAW, WDAT, WRSP} wstate_t;
   typedef enum logic [1:0] {RIDLE, RAR, RDAT} rstate_t;

   wstate_t     wstate_q, wstate_d;
   logic        wsel_q, wsel_d, wprev_q, wprev_d;
   logic [7:0]  wlen_q, wlen_d, wbeat_q, wbeat_d;
   logic        werr_q, werr_d;
   logic [15:0] werr_cnt_q, werr_cnt_d;

   rstate_t     rstate_q, rstate_d;
   logic        rsel_q, rsel_d, rprev_q, rprev_d;

   logic [A_WIDTH-1:0] aw_addr_g, ar_addr_g;
   logic [7:0]         aw_len_g, ar_len_g;
   logic [D_WIDTH-1:0] w_data_g;

   // A tie goes to the master that was not granted last; a lone requester wins.
   function automatic logic pick(input logic [1:0] req, input logic prev);
      if (req == 2'b11) return ~prev;
      return req[1];
   endfunction

   assign aw_addr_g = wsel_q ? m_awaddr[2*A_WIDTH-1:A_WIDTH] : m_awaddr[A_WIDTH-1:0];
   assign aw_len_g  = wsel_q ? m_awlen[15:8] : m_awlen[7:0];
   assign w_data_g  = wsel_q ? m_wdata[2*D_WIDTH-1:D_WIDTH] : m_wdata[D_WIDTH-1:0];
   assign ar_addr_g = rsel_q ? m_araddr[2*A_WIDTH-1:A_WIDTH] : m_araddr[A_WIDTH-1:0];
   assign ar_len_g  = rsel_q ? m_arlen[15:8] : m_arlen[7:0];

   // Read data needs no steering: only the granted master sees m_rvalid.
   assign m_rdata       = {2{s_rdata}};
   assign wlast_err     = werr_q;
   assign wlast_err_cnt = werr_cnt_q;

   always_comb begin
      wstate_d   = wstate_q;
      wsel_d     = wsel_q;
      wprev_d    = wprev_q;
      wlen_d     = wlen_q;
      wbeat_d    = wbeat_q;
      werr_d     = 1'b0;
      werr_cnt_d = werr_cnt_q;
      wgrant     = 2'b00;
      m_awready  = 2'b00;
      m_wready   = 2'b00;
      m_bvalid   = 2'b00;
      s_awvalid  = 1'b0;
      s_awaddr   = m_awaddr[A_WIDTH-1:0];
      s_awlen    = m_awlen[7:0];
      s_wvalid   = 1'b0;
      s_wlast    = 1'b0;
      s_wdata    = m_wdata[D_WIDTH-1:0];
      s_bready   = 1'b0;
      unique case (wstate_q)
         WIDLE: begin
            if (|m_awvalid) begin
               wsel_d   = pick(m_awvalid, wprev_q);
               wstate_d = WAW;
            end
         end
         WAW: begin
            wgrant[wsel_q]    = 1'b1;
            s_awvalid         = m_awvalid[wsel_q];
            s_awaddr          = aw_addr_g;
            s_awlen           = aw_len_g;
            m_awready[wsel_q] = s_awready;
            if (m_awvalid[wsel_q] && s_awready) begin
               wlen_d   = aw_len_g;
               wbeat_d  = 8'd0;
               wstate_d = WDAT;
            end
         end
         WDAT: begin
            wgrant[wsel_q]   = 1'b1;
            s_wvalid         = m_wvalid[wsel_q];
            s_wdata          = w_data_g;
            s_wlast          = m_wlast[wsel_q];
            m_wready[wsel_q] = s_wready;
            if (m_wvalid[wsel_q] && s_wready) begin
               wbeat_d = wbeat_q + 8'd1;
               // The beat is forwarded as-is; a mismatch is only reported.
               if (m_wlast[wsel_q] != (wbeat_q == wlen_q)) begin
                  werr_d = 1'b1;
                  if (werr_cnt_q != 16'hFFFF) werr_cnt_d = werr_cnt_q + 16'd1;
               end
               if (m_wlast[wsel_q]) wstate_d = WRSP;
            end
         end
         WRSP: begin
            wgrant[wsel_q]   = 1'b1;
            m_bvalid[wsel_q] = s_bvalid;
            s_bready         = m_bready[wsel_q];
            if (s_bvalid && m_bready[wsel_q]) begin
               wprev_d  = wsel_q;
               wstate_d = WIDLE;
            end
         end
         default: wstate_d = WIDLE;
      endcase
   end

   always_comb begin
      rstate_d  = rstate_q;
      rsel_d    = rsel_q;
      rprev_d   = rprev_q;
      rgrant    = 2'b00;
      m_arready = 2'b00;
      m_rvalid  = 2'b00;
      m_rlast   = 2'b00;
      s_arvalid = 1'b0;
      s_araddr  = m_araddr[A_WIDTH-1:0];
      s_arlen   = m_arlen[7:0];
      s_rready  = 1'b0;
      unique case (rstate_q)
         RIDLE: begin
            if (|m_arvalid) begin
               rsel_d   = pick(m_arvalid, rprev_q);
               rstate_d = RAR;
            end
         end
         RAR: begin
            rgrant[rsel_q]    = 1'b1;
            s_arvalid         = m_arvalid[rsel_q];
            s_araddr          = ar_addr_g;
            s_arlen           = ar_len_g;
            m_arready[rsel_q] = s_arready;
            if (m_arvalid[rsel_q] && s_arready) rstate_d = RDAT;
         end
         RDAT: begin
            rgrant[rsel_q]   = 1'b1;
            m_rvalid[rsel_q] = s_rvalid;
            m_rlast[rsel_q]  = s_rlast;
            s_rready         = m_rready[rsel_q];
            if (s_rvalid && m_rready[rsel_q] && s_rlast) begin
               rprev_d  = rsel_q;
               rstate_d = RIDLE;
            end
         end
         default: rstate_d = RIDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wstate_q   <= WIDLE;
         wsel_q     <= 1'b0;
         wprev_q    <= 1'b1;
         wlen_q     <= 8'd0;
         wbeat_q    <= 8'd0;
         werr_q     <= 1'b0;
         werr_cnt_q <= 16'd0;
         rstate_q   <= RIDLE;
         rsel_q     <= 1'b0;
         rprev_q    <= 1'b1;
      end else begin
         wstate_q   <= wstate_d;
         wsel_q     <= wsel_d;
         wprev_q    <= wprev_d;
         wlen_q     <= wlen_d;
         wbeat_q    <= wbeat_d;
         werr_q     <= werr_d;
         werr_cnt_q <= werr_cnt_d;
         rstate_q   <= rstate_d;
         rsel_q     <= rsel_d;
         rprev_q    <= rprev_d;
      end
   end

endmodule
